vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync block.
- Generalised to any mode via porch/sync/active parameters.
- Adds programmable sync polarity, pixel clock-enable, active-area pixel coordinates and line/frame start strobes.
- Sits between the system clock domain and the pixel/pattern generators; all downstream video logic keys off its outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync
VS_POL, 0, asserted level of vsync
HCW, 10, width of hc/px
VCW, 10, width of vc/py

Ports:
clk  input  1  system clock
clr_n  input  1  synchronous active-low reset
pix_ce  input  1  pixel advance enable; counters step only when 1
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
hc  output  HCW  horizontal counter, 0..H_TOTAL-1
vc  output  VCW  vertical counter, 0..V_TOTAL-1
vidon  output  1  1 inside active area
px  output  HCW  active x coordinate; 0 when vidon=0
py  output  VCW  active y coordinate; 0 when vidon=0
line_start  output  1  one-clk strobe when hc wraps to 0
frame_start  output  1  one-clk strobe when hc and vc both wrap to 0

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- Line order: sync, back porch, active, front porch. H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP.
- Reset: clr_n sampled on rising clk only; it overrides pix_ce.
- Reset values: hc=0, vc=0, hsync=HS_POL, vsync=VS_POL, vidon=0, px=0, py=0, line_start=0, frame_start=0.
- Counter stepping, per clk with pix_ce=1:
  - hc increments; at H_TOTAL-1, hc wraps to 0.
  - vc increments in the same edge as the hc wrap (no lag); at V_TOTAL-1, vc wraps to 0.
- pix_ce=0: all counters and level outputs hold.
- Every output is a flop and is consistent with the current hc/vc in the same cycle. This is computed from next-state counts; there is no combinational path from counters to ports.
- Level outputs:
  - hsync asserted iff hc < H_SYNC.
  - vsync asserted iff vc < V_SYNC.
  - vidon=1 iff H_START <= hc <= H_START+H_ACTIVE-1 and V_START <= vc <= V_START+V_ACTIVE-1 (both bounds inclusive).
  - px = hc-H_START and py = vc-V_START when vidon=1; otherwise 0.
- Strobes:
  - line_start=1 for exactly one clk, the cycle after a pix_ce edge that wrapped hc to 0.
  - frame_start=1 for exactly one clk, the cycle after a pix_ce edge that wrapped both counters to 0; line_start is also 1 in that cycle.
  - Strobes never stretch while pix_ce is low.
  - The post-reset state does not generate strobes; the first strobe comes on the first wrap.
- Reset mid-frame: counters return to 0 on the next edge regardless of pix_ce; any pending strobe is cleared.
- Illegal parameters (H_TOTAL > 2^HCW, V_TOTAL > 2^VCW, any sync width 0): elaboration fails via generate-time $error.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds parameter FCW (default 8) and output port frame_cnt (FCW bits).
  - frame_cnt resets to 0 and increments on the same edge that produces frame_start, wrapping modulo 2^FCW.
- Undefined: no frame_cnt port, no parameter, no associated logic.

Test Plan:
- Reset: clr_n=0 for 5 clks, pix_ce=1 -> hc=0, vc=0, hsync=0, vsync=0, vidon=0, strobes 0; after release, hc=1 on the first edge.
- Line timing, defaults, pix_ce=1:
  - hsync=0 for hc 0..95 and 1 for 96..799.
  - On vc=35: vidon first 1 at hc=144 (px=0) and last 1 at hc=783 (px=639).
  - vidon=0 for all vc<35 and vc>=515.
- Frame wrap: from hc=799, vc=524, one edge -> hc=0, vc=0, then line_start=1 and frame_start=1 for one clk; frame_start period = 420000 clks.
- pix_ce every 2nd clk -> line_start period 1600 clks; strobes exactly 1 clk wide; counters hold on ce=0 clks.
- Mid-frame reset: at hc=400, vc=200, pix_ce=0, clr_n=0 one clk -> next edge hc=0, vc=0, hsync=0, vidon=0, no strobe.
- Macro defined, FCW=2: after 5 frame_start strobes, frame_cnt=1 (wrapped 3->0 at the 4th); macro undefined -> module elaborates without the frame_cnt port.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces sync, active-video, pixel coordinates and line/frame strobes for
// any mode described by its porch/sync/active parameters. Counters step only
// when pix_ce is high. Every output is registered and computed from the
// next-state counts, so each port agrees with hc/vc in the same cycle.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add parameter FCW and
// output port frame_cnt, a free-running count of frame_start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HCW      = 10,
  parameter int VCW      = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
  , parameter int FCW    = 8
`endif
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic [HCW-1:0] hc,
  output logic [VCW-1:0] vc,
  output logic           vidon,
  output logic [HCW-1:0] px,
  output logic [VCW-1:0] py,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [FCW-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int H_LAST  = H_START + H_ACTIVE - 1;
  localparam int V_LAST  = V_START + V_ACTIVE - 1;

  // Reject geometries the counters cannot represent or that have no sync pulse.
  generate
    if (H_TOTAL > (1 << HCW)) begin : g_bad_htotal
      $error("vga_timing_gen: H_TOTAL does not fit in HCW bits");
    end
    if (V_TOTAL > (1 << VCW)) begin : g_bad_vtotal
      $error("vga_timing_gen: V_TOTAL does not fit in VCW bits");
    end
    if (H_SYNC == 0) begin : g_bad_hsync
      $error("vga_timing_gen: H_SYNC must be non-zero");
    end
    if (V_SYNC == 0) begin : g_bad_vsync
      $error("vga_timing_gen: V_SYNC must be non-zero");
    end
  endgenerate

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic [HCW-1:0] px_q, px_d;
  logic [VCW-1:0] py_q, py_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           vidon_q, vidon_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           hWrap, vWrap, hIn, vIn;

  // Next raster position: advance on pix_ce, wrapping hc and then vc.
  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    hWrap = 1'b0;
    vWrap = 1'b0;
    if (pix_ce) begin
      if (hc_q == HCW'(H_TOTAL - 1)) begin
        hc_d  = '0;
        hWrap = 1'b1;
        if (vc_q == VCW'(V_TOTAL - 1)) begin
          vc_d  = '0;
          vWrap = 1'b1;
        end else begin
          vc_d = vc_q + VCW'(1);
        end
      end else begin
        hc_d = hc_q + HCW'(1);
      end
    end
  end

  // Decode syncs, active area, coordinates and strobes from the next position.
  always_comb begin
    hIn           = (hc_d >= HCW'(H_START)) && (hc_d <= HCW'(H_LAST));
    vIn           = (vc_d >= VCW'(V_START)) && (vc_d <= VCW'(V_LAST));
    vidon_d       = hIn && vIn;
    hsync_d       = (hc_d < HCW'(H_SYNC)) ? HS_POL : ~HS_POL;
    vsync_d       = (vc_d < VCW'(V_SYNC)) ? VS_POL : ~VS_POL;
    px_d          = '0;
    py_d          = '0;
    if (vidon_d) begin
      px_d = hc_d - HCW'(H_START);
      py_d = vc_d - VCW'(V_START);
    end
    line_start_d  = hWrap;
    frame_start_d = hWrap && vWrap;
  end

  // State and output registers; reset wins over pix_ce.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      px_q          <= '0;
      py_q          <= '0;
      hsync_q       <= HS_POL;
      vsync_q       <= VS_POL;
      vidon_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      px_q          <= px_d;
      py_q          <= py_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vidon_q       <= vidon_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt_q;

  // Count frames on the same edge that raises frame_start, wrapping naturally.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + FCW'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign px          = px_q;
  assign py          = py_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vidon       = vidon_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
